// File: rtl/dragon_pkg.sv
// Shared definitions for the DragonHead datapath and its mode controller:
// behaviour-state encoding, field widths and location packing helpers.
// Location packing is {x[7:4], y[3:0]}.
package dragon_pkg;

  localparam int LOC_W = 8;
  localparam int LEN_W = 4;
  localparam int DIR_W = 2;

  // Encoding is visible to DragonHead, so values are fixed.
  typedef enum logic [1:0] {
    ST_CONTEST = 2'b00,
    ST_RETREAT = 2'b01,
    ST_SCATTER = 2'b10,
    ST_DEAD    = 2'b11
  } bstate_e;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  function automatic logic [3:0] loc_x(input logic [LOC_W-1:0] loc);
    return loc[7:4];
  endfunction

  function automatic logic [3:0] loc_y(input logic [LOC_W-1:0] loc);
    return loc[3:0];
  endfunction

  function automatic logic [LOC_W-1:0] loc_pack(input logic [3:0] x,
                                                input logic [3:0] y);
    return {x, y};
  endfunction

  // Saturating increment for body length.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len);
    return (len == LEN_MAX) ? len : len + 1'b1;
  endfunction

endpackage

// File: rtl/dragon_mode_ctrl_frame_divider.sv
// Move-pacing divider: counts 0..MOVE_DIV-1 while enabled and raises wrap
// (combinationally) on the frame the count rolls over. A synchronous clear
// restarts the count and suppresses wrap for that frame.
module frame_divider #(
  parameter int MOVE_DIV = 2
) (
  input  logic frame_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam logic [3:0] CNT_MAX = 4'(MOVE_DIV - 1);

  logic [3:0] cnt_q, cnt_d;

  // Next count and wrap strobe.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= CNT_MAX) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dragon_mode_ctrl.sv
// Behaviour-state scheduler for DragonHead. Owns the CONTEST / RETREAT /
// SCATTER / DEAD sequence, mode timer, body length and move pacing.
// Optional feature: define DRAGON_REGEN_EN to regrow one body segment every
// REGEN_FRAMES hurt-free frames spent in CONTEST.
module dragon_mode_ctrl
  import dragon_pkg::*;
#(
  parameter int               RETREAT_FRAMES = 12,
  parameter int               SCATTER_FRAMES = 8,
  parameter int               MOVE_DIV       = 2,
  parameter int               INIT_LENGTH    = 3,
  parameter logic [LOC_W-1:0] HOME_LOC       = 8'h00,
  parameter int               REGEN_FRAMES   = 32
) (
  input  logic             frame_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hurt_pulse,
  input  logic             sheep_eaten,
  input  logic             game_over,
  input  logic [LOC_W-1:0] head_location,
  output logic [1:0]       behaviour_state,
  output logic             move_en,
  output logic [LEN_W-1:0] body_length,
  output logic             dragon_hurt,
  output logic             dragon_win
);

  // Catch out-of-range configurations at elaboration.
  if (RETREAT_FRAMES < 1 || RETREAT_FRAMES > 255) begin : g_bad_retreat
    $error("dragon_mode_ctrl: RETREAT_FRAMES out of range");
  end
  if (SCATTER_FRAMES < 1 || SCATTER_FRAMES > 255) begin : g_bad_scatter
    $error("dragon_mode_ctrl: SCATTER_FRAMES out of range");
  end
  if (MOVE_DIV < 1 || MOVE_DIV > 15) begin : g_bad_div
    $error("dragon_mode_ctrl: MOVE_DIV out of range");
  end
  if (INIT_LENGTH < 1 || INIT_LENGTH > 15) begin : g_bad_len
    $error("dragon_mode_ctrl: INIT_LENGTH out of range");
  end
  if (REGEN_FRAMES < 1 || REGEN_FRAMES > 255) begin : g_bad_regen
    $error("dragon_mode_ctrl: REGEN_FRAMES out of range");
  end

  localparam logic [LEN_W-1:0] INIT_LEN  = LEN_W'(INIT_LENGTH);
  localparam logic [7:0]       RET_LOAD  = 8'(RETREAT_FRAMES);
  localparam logic [7:0]       SCAT_LOAD = 8'(SCATTER_FRAMES);

  bstate_e          state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       timer_q, timer_d;
  logic             move_en_q, move_en_d;
  logic             hurt_q, hurt_d;
  logic             win_q, win_d;
  logic             at_home;
  logic             div_en, div_clr, div_wrap;
`ifdef DRAGON_REGEN_EN
  logic [7:0]       regen_q, regen_d;
`endif

  // Home match compares both packed coordinates.
  assign at_home = (loc_x(head_location) == loc_x(HOME_LOC)) &&
                   (loc_y(head_location) == loc_y(HOME_LOC));

  // Divider runs only in the paced states and restarts on any state change,
  // so the first pulse lands MOVE_DIV frames after entering the state.
  assign div_en  = (state_q == ST_CONTEST) || (state_q == ST_SCATTER);
  assign div_clr = (state_d != state_q);

  frame_divider #(.MOVE_DIV(MOVE_DIV)) u_div (
    .frame_clk (frame_clk),
    .rst       (rst),
    .en        (div_en),
    .clr       (div_clr),
    .wrap      (div_wrap)
  );

  // Next-state, body length and mode timer, in event priority order.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    if (game_over) begin
      state_d = ST_DEAD;
    end else begin
      case (state_q)
        ST_DEAD: begin
          if (start) begin
            state_d = ST_CONTEST;
            len_d   = INIT_LEN;
          end
        end
        ST_CONTEST, ST_SCATTER: begin
          if (hurt_pulse) begin
            // Hurt wins over a same-frame sheep_eaten.
            if (len_q <= 1) begin
              state_d = ST_DEAD;
              len_d   = '0;
            end else begin
              state_d = ST_RETREAT;
              len_d   = len_q - 1'b1;
              timer_d = RET_LOAD;
            end
          end else if (state_q == ST_CONTEST) begin
            if (sheep_eaten) begin
              state_d = ST_SCATTER;
              len_d   = len_inc(len_q);
              timer_d = SCAT_LOAD;
            end
          end else begin
            timer_d = timer_q - 1'b1;
            if (timer_q <= 8'd1) state_d = ST_CONTEST;
          end
        end
        ST_RETREAT: begin
          // Invulnerable: hurt and sheep are ignored.
          timer_d = timer_q - 1'b1;
          if (timer_q <= 8'd1 || at_home) state_d = ST_CONTEST;
        end
        default: state_d = ST_DEAD;
      endcase
    end
`ifdef DRAGON_REGEN_EN
    // Regen counts only frames that stay in CONTEST without a hurt;
    // any other frame clears it.
    regen_d = '0;
    if (state_q == ST_CONTEST && state_d == ST_CONTEST && !hurt_pulse) begin
      if (regen_q >= 8'(REGEN_FRAMES - 1)) begin
        len_d = len_inc(len_q);
      end else begin
        regen_d = regen_q + 1'b1;
      end
    end
`endif
  end

  // Registered outputs derived from the next state.
  always_comb begin
    hurt_d    = (state_d == ST_RETREAT);
    win_d     = (state_d == ST_SCATTER);
    move_en_d = 1'b0;
    case (state_d)
      ST_RETREAT:             move_en_d = 1'b1;
      ST_CONTEST, ST_SCATTER: move_en_d = (state_d == state_q) && div_wrap;
      default:                move_en_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DEAD;
      len_q     <= INIT_LEN;
      timer_q   <= '0;
      move_en_q <= 1'b0;
      hurt_q    <= 1'b0;
      win_q     <= 1'b0;
`ifdef DRAGON_REGEN_EN
      regen_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      move_en_q <= move_en_d;
      hurt_q    <= hurt_d;
      win_q     <= win_d;
`ifdef DRAGON_REGEN_EN
      regen_q   <= regen_d;
`endif
    end
  end

  assign behaviour_state = state_q;
  assign body_length     = len_q;
  assign move_en         = move_en_q;
  assign dragon_hurt     = hurt_q;
  assign dragon_win      = win_q;

endmodule

// File: tb/tb_dragon_mode_ctrl.sv
// Directed bench for dragon_mode_ctrl at default parameters.
module tb_dragon_mode_ctrl;

  logic       frame_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hurt_pulse = 1'b0;
  logic       sheep_eaten = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] head_location = 8'h55;
  logic [1:0] behaviour_state;
  logic       move_en;
  logic [3:0] body_length;
  logic       dragon_hurt;
  logic       dragon_win;

  int total = 0;
  int fails = 0;

  always #5 frame_clk = ~frame_clk;

  dragon_mode_ctrl dut (
    .frame_clk       (frame_clk),
    .rst             (rst),
    .start           (start),
    .hurt_pulse      (hurt_pulse),
    .sheep_eaten     (sheep_eaten),
    .game_over       (game_over),
    .head_location   (head_location),
    .behaviour_state (behaviour_state),
    .move_en         (move_en),
    .body_length     (body_length),
    .dragon_hurt     (dragon_hurt),
    .dragon_win      (dragon_win)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset holds DEAD with initial length.
    tick(); tick();
    chk("rst_state", 8'(behaviour_state), 8'd3);
    chk("rst_len",   8'(body_length), 8'd3);
    chk("rst_move",  8'(move_en), 8'd0);
    chk("rst_hurt",  8'(dragon_hurt), 8'd0);
    chk("rst_win",   8'(dragon_win), 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_dead", 8'(behaviour_state), 8'd3);

    // Start: CONTEST, move_en every 2nd frame.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_state", 8'(behaviour_state), 8'd0);
    chk("start_len",   8'(body_length), 8'd3);
    chk("start_move0", 8'(move_en), 8'd0);
    tick(); chk("move_f1", 8'(move_en), 8'd0);
    tick(); chk("move_f2", 8'(move_en), 8'd1);
    tick(); chk("move_f3", 8'(move_en), 8'd0);
    tick(); chk("move_f4", 8'(move_en), 8'd1);

    // Hurt at length 3 -> RETREAT for exactly 12 frames.
    hurt_pulse = 1'b1; tick(); hurt_pulse = 1'b0;
    chk("ret_state", 8'(behaviour_state), 8'd1);
    chk("ret_len",   8'(body_length), 8'd2);
    chk("ret_hurt",  8'(dragon_hurt), 8'd1);
    chk("ret_move0", 8'(move_en), 8'd1);
    hurt_pulse = 1'b1; tick(); hurt_pulse = 1'b0;
    chk("ret_invuln_state", 8'(behaviour_state), 8'd1);
    chk("ret_invuln_len",   8'(body_length), 8'd2);
    for (int i = 2; i <= 11; i++) tick();
    chk("ret_f11_state", 8'(behaviour_state), 8'd1);
    chk("ret_f11_move",  8'(move_en), 8'd1);
    tick();
    chk("ret_exit_state", 8'(behaviour_state), 8'd0);
    chk("ret_exit_hurt",  8'(dragon_hurt), 8'd0);
    chk("ret_exit_move",  8'(move_en), 8'd0);

    // Early exit on reaching home.
    hurt_pulse = 1'b1; tick(); hurt_pulse = 1'b0;
    chk("home_enter_len", 8'(body_length), 8'd1);
    tick(); tick();
    chk("home_f2_state", 8'(behaviour_state), 8'd1);
    head_location = 8'h00; tick(); head_location = 8'h55;
    chk("home_exit_state", 8'(behaviour_state), 8'd0);

    // Hurt + sheep together at length 1 -> DEAD, length 0.
    hurt_pulse = 1'b1; sheep_eaten = 1'b1; tick();
    hurt_pulse = 1'b0; sheep_eaten = 1'b0;
    chk("die_state", 8'(behaviour_state), 8'd3);
    chk("die_len",   8'(body_length), 8'd0);
    tick(); chk("die_move", 8'(move_en), 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_state", 8'(behaviour_state), 8'd0);
    chk("restart_len",   8'(body_length), 8'd3);

    // Grow to 15 through repeated SCATTER rounds of 8 frames.
    for (int k = 0; k < 12; k++) begin
      sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
      chk("scat_state", 8'(behaviour_state), 8'd2);
      chk("scat_win",   8'(dragon_win), 8'd1);
      for (int j = 1; j <= 7; j++) begin
        if (j == 3) sheep_eaten = 1'b1;
        tick();
        sheep_eaten = 1'b0;
        if (k == 0 && j == 1) chk("scat_move_f1", 8'(move_en), 8'd0);
        if (k == 0 && j == 2) chk("scat_move_f2", 8'(move_en), 8'd1);
      end
      chk("scat_f7_state", 8'(behaviour_state), 8'd2);
      tick();
      chk("scat_exit_state", 8'(behaviour_state), 8'd0);
      chk("scat_exit_win",   8'(dragon_win), 8'd0);
      chk("scat_len",        8'(body_length), 8'(4 + k));
    end

    // Sheep at 15 saturates, SCATTER still 8 frames.
    sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
    chk("sat_state", 8'(behaviour_state), 8'd2);
    chk("sat_len",   8'(body_length), 8'd15);
    for (int j = 1; j <= 7; j++) tick();
    chk("sat_f7_win", 8'(dragon_win), 8'd1);
    tick();
    chk("sat_exit_win", 8'(dragon_win), 8'd0);

    // Hurt inside SCATTER at 15 -> RETREAT, 14.
    sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
    chk("sat2_len", 8'(body_length), 8'd15);
    tick(); tick();
    hurt_pulse = 1'b1; tick(); hurt_pulse = 1'b0;
    chk("scat_hurt_state", 8'(behaviour_state), 8'd1);
    chk("scat_hurt_len",   8'(body_length), 8'd14);
    chk("scat_hurt_win",   8'(dragon_win), 8'd0);
    head_location = 8'h00; tick(); head_location = 8'h55;
    chk("back_contest", 8'(behaviour_state), 8'd0);

    // game_over during SCATTER; start ignored while it is high.
    sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
    chk("go_pre_state", 8'(behaviour_state), 8'd2);
    game_over = 1'b1; start = 1'b1; tick();
    chk("go_state", 8'(behaviour_state), 8'd3);
    chk("go_win",   8'(dragon_win), 8'd0);
    tick();
    chk("go_start_ignored", 8'(behaviour_state), 8'd3);
    game_over = 1'b0; start = 1'b0; tick();
    chk("go_dead_hold", 8'(behaviour_state), 8'd3);
    chk("go_move",      8'(move_en), 8'd0);

    // Long hurt-free CONTEST: regen only when the feature is built in.
    start = 1'b1; tick(); start = 1'b0;
    chk("regen_start_len", 8'(body_length), 8'd3);
    for (int i = 0; i < 31; i++) tick();
    chk("regen_f31_len", 8'(body_length), 8'd3);
    tick();
`ifdef DRAGON_REGEN_EN
    chk("regen_f32_len", 8'(body_length), 8'd4);
`else
    chk("noregen_f32_len", 8'(body_length), 8'd3);
`endif

    // Async reset mid-round takes effect without a clock edge.
    sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
    #2 rst = 1'b1; #1;
    chk("async_rst_state", 8'(behaviour_state), 8'd3);
    chk("async_rst_len",   8'(body_length), 8'd3);
    chk("async_rst_win",   8'(dragon_win), 8'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/dragon_mode_ctrl.md
# dragon_mode_ctrl

Behaviour-state scheduler for the DragonHead datapath. It owns the dragon's contest/retreat/scatter/dead state sequence, mode timers, body-length bookkeeping and per-frame move pacing. It turns per-frame game events (hurt, sheep eaten, game over) into the `behaviour_state`, `move_en`, `body_length`, `dragon_hurt` and `dragon_win` signals that DragonHead consumes. It sits between the game-event logic and DragonHead, and runs on the frame clock.

## Interface
- `RETREAT_FRAMES`, default 12: frames spent in RETREAT. Range 1..255.
- `SCATTER_FRAMES`, default 8: frames spent in SCATTER. Range 1..255.
- `MOVE_DIV`, default 2: frames per dragon step in CONTEST and SCATTER. Range 1..15.
- `INIT_LENGTH`, default 3: body length loaded on start. Range 1..15.
- `HOME_LOC`, default 8'h00: retreat target, packed {x[7:4], y[3:0]}.
- `REGEN_FRAMES`, default 32: regen interval. Used only with `DRAGON_REGEN_EN`. Range 1..255.

Ports (name, direction, width, meaning):
- `frame_clk` in 1: frame clock. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a round. Honoured only in DEAD.
- `hurt_pulse` in 1: the player struck the dragon this frame.
- `sheep_eaten` in 1: the dragon head reached the sheep this frame.
- `game_over` in 1: level; global end of game.
- `head_location` in 8: current dragon head location {x, y}.
- `behaviour_state` out 2: 00 CONTEST, 01 RETREAT, 10 SCATTER, 11 DEAD.
- `move_en` out 1: one-frame pulse telling DragonHead to step.
- `body_length` out 4: current body length.
- `dragon_hurt` out 1: high while in RETREAT.
- `dragon_win` out 1: high while in SCATTER.

## Operation
- All outputs are registered.
- Reset values: `behaviour_state`=DEAD, `body_length`=INIT_LENGTH, `move_en`=0, `dragon_hurt`=0, `dragon_win`=0. Mode timer, divider and regen counter reset to 0.

Priority per frame, highest first:
1. `game_over` is high: go to DEAD from any state. `start` is ignored while `game_over` is high.
2. In DEAD, `start` is high: go to CONTEST, load `body_length`=INIT_LENGTH.
3. In CONTEST or SCATTER, `hurt_pulse` is high:
   - If `body_length`==1: go to DEAD and set `body_length`=0.
   - Otherwise: decrement `body_length`, go to RETREAT, load timer=RETREAT_FRAMES.
   - Any simultaneous `sheep_eaten` is dropped.
4. In CONTEST, `sheep_eaten` is high: increment `body_length`, saturating at 15. Go to SCATTER, load timer=SCATTER_FRAMES.
5. In RETREAT:
   - `hurt_pulse` and `sheep_eaten` are ignored (the dragon is invulnerable).
   - The timer decrements each frame.
   - Exit to CONTEST when the timer decrements from 1, or when `head_location`==HOME_LOC, whichever comes first.
6. In SCATTER:
   - `sheep_eaten` is ignored.
   - The timer decrements each frame; exit to CONTEST when it decrements from 1.

Move pacing:
- In CONTEST and SCATTER, a divider counts 0..MOVE_DIV-1. `move_en` is high for the frame following the wrap. The first pulse comes MOVE_DIV frames after entering the state, then one every MOVE_DIV frames.
- In RETREAT, `move_en` is high every frame.
- In DEAD, `move_en` is 0.
- The divider clears on every state change.

Arithmetic:
- `body_length` is 4-bit unsigned and never wraps: it saturates at 15 and floors at 0, where 0 occurs only in DEAD.
- The timer is 8-bit unsigned.

## Timing
- Latency from an event input sampled at edge N to the updated outputs is 1 frame: outputs are valid after edge N.
- `dragon_hurt` and `dragon_win` change in the same frame as `behaviour_state`.
- RETREAT lasts exactly RETREAT_FRAMES frames unless cut short by the HOME_LOC match. SCATTER lasts exactly SCATTER_FRAMES frames.
- Asserting `rst` mid-round forces the reset values immediately, with no clock edge needed.
- Deasserting `rst` leaves the block in DEAD until `start`.
- Events arriving on the same edge as a state exit are evaluated against the pre-edge state.

## Configuration
- `DRAGON_REGEN_EN` defined:
  - In CONTEST, a regen counter counts frames without `hurt_pulse`.
  - When it reaches REGEN_FRAMES, `body_length` increments (saturating at 15) and the counter clears.
  - The counter clears on any hurt and on leaving CONTEST.
- `DRAGON_REGEN_EN` undefined: the regen counter is absent, and `body_length` changes only on start, hurt and sheep_eaten.

## Structure
- Shared package `dragon_pkg` holds:
  - Behaviour-state encoding constants (CONTEST, RETREAT, SCATTER, DEAD).
  - `LOC_W`=8, `LEN_W`=4, `DIR_W`=2.
  - The location packing helpers (x = [7:4], y = [3:0]).
- DragonHead imports the same package.
- Sub-module `frame_divider`: MOVE_DIV counter with a synchronous clear and a wrap pulse output, instantiated once for `move_en`.

## Test plan
- Reset then start: `rst` pulse, `start`=1 for 1 frame → `behaviour_state`=00 and `body_length`=3 after the next edge. With MOVE_DIV=2, `move_en` pulses every 2nd frame.
- Hurt in CONTEST with length 3 → RETREAT, `body_length`=2, `dragon_hurt`=1, `move_en`=1 every frame. Back to CONTEST after exactly 12 frames with `head_location`≠HOME_LOC. A second `hurt_pulse` during RETREAT has no effect.
- Retreat early exit: enter RETREAT, drive `head_location`=8'h00 on frame 3 → CONTEST on the following frame.
- Sheep eaten with length 15 → SCATTER, `body_length` stays 15, `dragon_win`=1 for 8 frames. A `hurt_pulse` in SCATTER at length 15 → RETREAT, `body_length`=14.
- Simultaneous `hurt_pulse` and `sheep_eaten` at length 1 → DEAD, `body_length`=0. `start` then → CONTEST, `body_length`=3.
- `game_over`=1 during SCATTER → DEAD next frame. `start` is ignored while `game_over`=1.
- With `DRAGON_REGEN_EN` defined: 32 hurt-free CONTEST frames → `body_length` increments by 1.
